// File: rtl/ex_alu_arbiter.sv
// Two-requester arbiter for the single EX-stage ALU: fixed priority to Req0,
// with a starvation counter that eventually forces a Req1 grant.
module ex_alu_arbiter #(
    parameter int ALU_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        ClockInput,
    input  logic        ResetInput,
    input  logic        Req0Valid,
    input  logic [31:0] Req0Instruction,
    input  logic [31:0] Req0PriOperand,
    input  logic [31:0] Req0SecOperand,
    output logic        Req0Ready,
    input  logic        Req1Valid,
    input  logic [31:0] Req1Instruction,
    input  logic [31:0] Req1PriOperand,
    input  logic [31:0] Req1SecOperand,
    output logic        Req1Ready,
    output logic [31:0] AluInstruction,
    output logic [31:0] AluPriOperand,
    output logic [31:0] AluSecOperand,
    input  logic [31:0] AluResult,
    input  logic        AluZeroFlag,
    output logic        Rsp0Valid,
    output logic        Rsp1Valid,
    output logic [31:0] RspResult,
    output logic        RspZeroFlag,
    output logic        Busy
);

    localparam logic [CNT_W-1:0] LAT_INIT   = CNT_W'(ALU_LATENCY);
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] lat_cnt;
    logic [CNT_W-1:0] starve_cnt;
    logic             owner;
    logic             grant0;
    logic             grant1;
    logic             accept;
    logic             lat_done;

    assign lat_done = (lat_cnt == CNT_ONE);

    // Winner selection and next state; grants exist only in IDLE and never during reset.
    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                if (!ResetInput) begin
                    if (Req1Valid && (!Req0Valid || starve_cnt == STARVE_MAX)) begin
                        grant1 = 1'b1;
                    end else if (Req0Valid) begin
                        grant0 = 1'b1;
                    end
                end
                if (grant0 || grant1) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (lat_done) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign accept    = grant0 || grant1;
    assign Req0Ready = grant0;
    assign Req1Ready = grant1;
    assign Busy      = (state == EXEC) || (state == DONE);

    always_ff @(posedge ClockInput or posedge ResetInput) begin
        if (ResetInput) begin
            state      <= IDLE;
            lat_cnt    <= '0;
            starve_cnt <= '0;
            owner      <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && accept) begin
                owner   <= grant1;
                lat_cnt <= LAT_INIT;
                if (grant0 && Req1Valid) begin
                    if (starve_cnt != STARVE_MAX) begin
                        starve_cnt <= starve_cnt + CNT_ONE;
                    end
                end else begin
                    starve_cnt <= '0;
                end
            end else if (state == EXEC) begin
                lat_cnt <= lat_cnt - CNT_ONE;
            end
        end
    end

    // Launch stage: operands of the winner drive the ALU until the next accept.
    always_ff @(posedge ClockInput or posedge ResetInput) begin
        if (ResetInput) begin
            AluInstruction <= '0;
            AluPriOperand  <= '0;
            AluSecOperand  <= '0;
        end else if (state == IDLE && accept) begin
            AluInstruction <= grant1 ? Req1Instruction : Req0Instruction;
            AluPriOperand  <= grant1 ? Req1PriOperand  : Req0PriOperand;
            AluSecOperand  <= grant1 ? Req1SecOperand  : Req0SecOperand;
        end
    end

    // Response stage: result captured once the latency count expires, pulsed to the owner.
    always_ff @(posedge ClockInput or posedge ResetInput) begin
        if (ResetInput) begin
            RspResult   <= '0;
            RspZeroFlag <= 1'b0;
            Rsp0Valid   <= 1'b0;
            Rsp1Valid   <= 1'b0;
        end else if (state == EXEC && lat_done) begin
            RspResult   <= AluResult;
            RspZeroFlag <= AluZeroFlag;
            Rsp0Valid   <= !owner;
            Rsp1Valid   <= owner;
        end else begin
            Rsp0Valid <= 1'b0;
            Rsp1Valid <= 1'b0;
        end
    end

endmodule
